bcd_to_bin: RTL and testbench

- Sequential converter from 4-digit packed BCD (0000–9999) to unsigned binary, using reverse double dabble (shift right, then subtract 3 from each BCD column ≥ 8).
- Inverse partner of the team's binary-to-BCD block.
- Takes keypad or switch-entered decimal values and turns them into binary setpoints for downstream arithmetic, PWM and compare logic.
- Uses a start/ready/done handshake, so the result is never taken from a partially shifted register.

---
 rtl/bcd_to_bin.sv | 134 +++++++++++++
 tb/tb_bcd_to_bin.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// Sequential 4-digit packed BCD to binary converter using reverse double dabble.
// Start/ready/done handshake; invalid digits short-circuit to ERR_CODE in one cycle.
module bcd_to_bin #(
    parameter logic [15:0] ERR_CODE = 16'hEEEE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bcd_in,
    input  logic        start,
    output logic [15:0] bin_out,
    output logic        ready,
    output logic        done,
    output logic        error
);

    localparam int unsigned BCD_W  = 16;
    localparam int unsigned SCR_W  = 32;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned N_ITER = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [BCD_W-1:0]   bin_q, bin_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               bcd_valid_c;

    // One reverse-dabble step: shift right, then pull each BCD column >= 8 down by 3.
    function automatic logic [SCR_W-1:0] shift_correct(input logic [SCR_W-1:0] s);
        logic [SCR_W-1:0] r;
        r = s >> 1;
        for (int i = 4; i < 8; i++) begin
            if (r[i*4 +: 4] >= 4'd8) begin
                r[i*4 +: 4] = r[i*4 +: 4] - 4'd3;
            end
        end
        return r;
    endfunction

    always_comb begin
        bcd_valid_c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (bcd_in[i*4 +: 4] > 4'd9) begin
                bcd_valid_c = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            scratch_q <= '0;
            count_q   <= '0;
            bin_q     <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            count_q   <= count_d;
            bin_q     <= bin_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        scratch_d = scratch_q;
        count_d   = count_q;
        bin_d     = bin_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        error_d   = error_q;

        unique case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (start && ready_q) begin
                    if (!bcd_valid_c) begin
                        bin_d   = ERR_CODE;
                        error_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        scratch_d = {bcd_in, BCD_W'(0)};
                        count_d   = '0;
                        ready_d   = 1'b0;
                        state_d   = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                // Out-of-range count can only come from corruption; bail back to idle.
                if (count_q >= CNT_W'(N_ITER)) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end else begin
                    scratch_d = shift_correct(scratch_q);
                    count_d   = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(N_ITER - 1)) begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                bin_d   = scratch_q[BCD_W-1:0];
                error_d = 1'b0;
                done_d  = 1'b1;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    assign bin_out = bin_q;
    assign ready   = ready_q;
    assign done    = done_q;
    assign error   = error_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Bench for bcd_to_bin: fixed vector table, handshake corner sequences and
// randomized conversions against a decimal-arithmetic reference.
module tb_bcd_to_bin;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bcd_in;
    logic        start;
    logic [15:0] bin_out;
    logic        ready;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_to_bin dut (
        .clk     (clk),
        .reset   (reset),
        .bcd_in  (bcd_in),
        .start   (start),
        .bin_out (bin_out),
        .ready   (ready),
        .done    (done),
        .error   (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        logic [15:0] exp_bin;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decimal reference: weigh the four digits arithmetically.
    function automatic void ref_conv(input logic [15:0] bcd, output logic [15:0] bin,
                                     output logic err);
        int d3, d2, d1, d0;
        d3 = int'(bcd[15:12]);
        d2 = int'(bcd[11:8]);
        d1 = int'(bcd[7:4]);
        d0 = int'(bcd[3:0]);
        err = (d3 > 9) || (d2 > 9) || (d1 > 9) || (d0 > 9);
        bin = err ? 16'hEEEE : 16'(d3 * 1000 + d2 * 100 + d1 * 10 + d0);
    endfunction

    // Issue one start from idle and check result, latency and pulse width.
    task automatic run(input string name, input logic [15:0] bcd,
                       input logic [15:0] exp_bin, input logic exp_err);
        int k;
        int exp_lat;
        exp_lat = exp_err ? 0 : 17;
        bcd_in = bcd;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({name, " done"}, 32'(done), 32'd1);
        chk({name, " latency"}, 32'(k), 32'(exp_lat));
        chk({name, " bin_out"}, 32'(bin_out), 32'(exp_bin));
        chk({name, " error"}, 32'(error), 32'(exp_err));
        chk({name, " ready"}, 32'(ready), 32'd1);
        @(negedge clk);
        chk({name, " done width"}, 32'(done), 32'd0);
        chk({name, " bin_out hold"}, 32'(bin_out), 32'(exp_bin));
    endtask

    initial begin
        logic [15:0] rb;
        logic        re;
        logic [15:0] r_bcd;
        int          pulses;
        int          last_k;
        logic [15:0] seen_bin;

        vecs[0] = '{16'h1234, 16'h04D2, 1'b0};
        vecs[1] = '{16'h9999, 16'h270F, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b0};
        vecs[3] = '{16'h0010, 16'h000A, 1'b0};
        vecs[4] = '{16'h12A4, 16'hEEEE, 1'b1};
        vecs[5] = '{16'h0005, 16'h0005, 1'b0};
        vecs[6] = '{16'hF000, 16'hEEEE, 1'b1};
        vecs[7] = '{16'h8080, 16'h1F90, 1'b0};

        reset  = 1'b1;
        start  = 1'b0;
        bcd_in = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset bin_out", 32'(bin_out), 32'd0);
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset done", 32'(done), 32'd0);
        chk("reset error", 32'(error), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].exp_bin, vecs[i].exp_err);
        end

        // Input changes and a second start during a conversion must be ignored.
        bcd_in = 16'h4321;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        pulses = 0;
        seen_bin = 16'h0000;
        for (int k = 0; k < 40; k++) begin
            if (k == 3) begin
                bcd_in = 16'h9999;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                pulses++;
                seen_bin = bin_out;
            end
            @(negedge clk);
        end
        chk("ignore pulses", 32'(pulses), 32'd1);
        chk("ignore bin_out", 32'(seen_bin), 32'h10E1);

        // Reset in the middle of a conversion aborts it silently.
        bcd_in = 16'h5678;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        pulses = 0;
        for (int k = 0; k < 7; k++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort bin_out", 32'(bin_out), 32'd0);
        chk("abort ready", 32'(ready), 32'd1);
        chk("abort error", 32'(error), 32'd0);
        for (int k = 0; k < 25; k++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        chk("abort pulses", 32'(pulses), 32'd0);
        run("after abort", 16'h0042, 16'h002A, 1'b0);

        // Start held high: back-to-back conversions every 18 cycles.
        bcd_in = 16'h0100;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pulses = 0;
        last_k = -1;
        for (int k = 0; k < 60; k++) begin
            if (done) begin
                pulses++;
                chk($sformatf("hold bin_out %0d", pulses), 32'(bin_out), 32'h0064);
                if (last_k < 0) chk("hold first latency", 32'(k), 32'd17);
                else chk($sformatf("hold period %0d", pulses), 32'(k - last_k), 32'd18);
                last_k = k;
            end
            @(negedge clk);
        end
        chk("hold pulses", 32'(pulses), 32'd3);
        start = 1'b0;
        begin
            int w;
            w = 0;
            while (!ready && w < 40) begin
                @(negedge clk);
                w++;
            end
            chk("hold drain ready", 32'(ready), 32'd1);
            @(negedge clk);
        end

        // Randomized digits, occasionally including invalid nibbles.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                r_bcd = 16'($urandom);
            end else begin
                r_bcd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                         4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            end
            ref_conv(r_bcd, rb, re);
            run($sformatf("rand %04h", r_bcd), r_bcd, rb, re);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
